// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage with req/ready data-memory handshake, WB->MEM store forwarding and the MEM/WB register
//   Optional feature macro: MEM_TIMEOUT_EN (aborts a WAIT after TIMEOUT_CYCLES cycles and sets sticky mem_err)
//   Ports: clk, rst_n (sync, active-low)
//          in_*           EX/MEM register outputs (address/result, store data, control, dst/rt regs)
//          wb_*           WB stage write port used as the store-data forward source
//          mem_*          data memory request side (req/we/addr/wdata out, rdata/ready in)
//          mem_stall      freezes the upstream pipeline; mem_err sticky timeout; stall_cycles saturating count
//          out_*          registered MEM/WB outputs to WB
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_ALU_result,
    input  logic [15:0] in_SW_data,
    input  logic        in_MemWrite,
    input  logic        in_MemRead,
    input  logic        in_MemToReg,
    input  logic        in_RegWrite,
    input  logic        in_HLT,
    input  logic [3:0]  in_DstReg,
    input  logic [3:0]  in_RT,
    input  logic        wb_RegWrite,
    input  logic [3:0]  wb_DstReg,
    input  logic [15:0] wb_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [15:0] stall_cycles,
    output logic [15:0] out_ALU_result,
    output logic [15:0] out_Mem_data,
    output logic        out_MemToReg,
    output logic        out_RegWrite,
    output logic        out_HLT,
    output logic [3:0]  out_DstReg
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state;
    logic [15:0] wdata_hold;
    logic [15:0] store_data;
    logic        memop;
    logic        fwd;
    logic        adv;
    logic        tmo;
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    assign memop      = in_MemRead | in_MemWrite;
    assign fwd        = in_MemWrite & wb_RegWrite & (wb_DstReg == in_RT) & (wb_DstReg != 4'd0);
    assign store_data = fwd ? wb_data : in_SW_data;
    // WAIT keeps the request up from the frozen EX/MEM values; a timed-out WAIT drops it
    assign mem_req    = rst_n & ((state == WAIT) ? ~tmo : memop);
    assign mem_we     = mem_req & in_MemWrite;
    assign mem_addr   = mem_req ? in_ALU_result : 16'd0;
    assign mem_wdata  = mem_req ? ((state == WAIT) ? wdata_hold : store_data) : 16'd0;
    assign mem_stall  = mem_req & ~mem_ready;
    assign adv        = ~mem_stall;
`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt;
    // wait_cnt reaches TMO only after TIMEOUT_CYCLES stalled WAIT cycles; that next cycle is the abort cycle
    assign tmo = (state == WAIT) && (wait_cnt == TMO);
`else
    assign tmo     = 1'b0;
    assign mem_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            wdata_hold     <= 16'd0;
            stall_cycles   <= 16'd0;
            out_ALU_result <= 16'd0;
            out_Mem_data   <= 16'd0;
            out_MemToReg   <= 1'b0;
            out_RegWrite   <= 1'b0;
            out_HLT        <= 1'b0;
            out_DstReg     <= 4'd0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt       <= 16'd0;
            mem_err        <= 1'b0;
`endif
        end else begin
            stall_cycles <= (mem_stall && stall_cycles != 16'hFFFF) ? stall_cycles + 16'd1 : stall_cycles;
            if (state == IDLE) begin
                if (memop && !mem_ready) begin
                    state      <= WAIT;
                    wdata_hold <= store_data;
                end
            end else if (mem_ready || tmo) begin
                state <= IDLE;
            end
            // stalled cycles load a bubble; an aborted op passes through with RegWrite suppressed
            out_ALU_result <= in_ALU_result;
            out_DstReg     <= in_DstReg;
            out_RegWrite   <= adv & in_RegWrite & ~tmo;
            out_MemToReg   <= adv & in_MemToReg;
            out_HLT        <= out_HLT | (adv & in_HLT);
            if (mem_req && mem_ready && !in_MemWrite) out_Mem_data <= mem_rdata;
`ifdef MEM_TIMEOUT_EN
            wait_cnt <= (state == WAIT && !mem_ready) ? wait_cnt + 16'd1 : 16'd0;
            mem_err  <= mem_err | (state == WAIT && !mem_ready && wait_cnt == TMO - 16'd1);
`endif
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_ALU_result, in_SW_data, wb_data, mem_rdata;
    logic        in_MemWrite, in_MemRead, in_MemToReg, in_RegWrite, in_HLT;
    logic [3:0]  in_DstReg, in_RT, wb_DstReg;
    logic        wb_RegWrite, mem_ready;
    logic        mem_req, mem_we, mem_stall, mem_err;
    logic [15:0] mem_addr, mem_wdata, stall_cycles, out_ALU_result, out_Mem_data;
    logic        out_MemToReg, out_RegWrite, out_HLT;
    logic [3:0]  out_DstReg;
    int n_vec = 0;
    int n_err = 0;
    mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_ALU_result(in_ALU_result), .in_SW_data(in_SW_data),
        .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead), .in_MemToReg(in_MemToReg),
        .in_RegWrite(in_RegWrite), .in_HLT(in_HLT), .in_DstReg(in_DstReg), .in_RT(in_RT),
        .wb_RegWrite(wb_RegWrite), .wb_DstReg(wb_DstReg), .wb_data(wb_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .out_ALU_result(out_ALU_result), .out_Mem_data(out_Mem_data),
        .out_MemToReg(out_MemToReg), .out_RegWrite(out_RegWrite), .out_HLT(out_HLT),
        .out_DstReg(out_DstReg)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_in();
        in_ALU_result = 16'd0; in_SW_data = 16'd0; in_MemWrite = 1'b0; in_MemRead = 1'b0;
        in_MemToReg = 1'b0; in_RegWrite = 1'b0; in_HLT = 1'b0; in_DstReg = 4'd0; in_RT = 4'd0;
        wb_RegWrite = 1'b0; wb_DstReg = 4'd0; wb_data = 16'd0; mem_rdata = 16'd0; mem_ready = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0;
        clear_in();
        tick(); tick();
        chk("rst_alu", out_ALU_result, 16'd0);
        chk("rst_regwrite", 16'(out_RegWrite), 16'd0);
        chk("rst_req", 16'(mem_req), 16'd0);
        chk("rst_stall_cycles", stall_cycles, 16'd0);
        chk("rst_err", 16'(mem_err), 16'd0);
        rst_n = 1'b1;
        // passthrough, no memop
        in_ALU_result = 16'h1234; in_RegWrite = 1'b1; in_DstReg = 4'd3;
        #1;
        chk("pass_req", 16'(mem_req), 16'd0);
        chk("pass_stall", 16'(mem_stall), 16'd0);
        tick();
        chk("pass_alu", out_ALU_result, 16'h1234);
        chk("pass_regwrite", 16'(out_RegWrite), 16'd1);
        chk("pass_dst", 16'(out_DstReg), 16'd3);
        // load, ready after three stalled cycles
        in_ALU_result = 16'h0040; in_MemRead = 1'b1; in_MemToReg = 1'b1; in_DstReg = 4'd7;
        #1;
        chk("ld_req", 16'(mem_req), 16'd1);
        chk("ld_we", 16'(mem_we), 16'd0);
        chk("ld_addr", mem_addr, 16'h0040);
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", 16'(mem_stall), 16'd1);
            tick();
            chk("ld_bubble", 16'(out_RegWrite), 16'd0);
        end
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        chk("ld_done_stall", 16'(mem_stall), 16'd0);
        chk("ld_done_req", 16'(mem_req), 16'd1);
        tick();
        clear_in();
        #1;
        chk("ld_data", out_Mem_data, 16'hBEEF);
        chk("ld_regwrite", 16'(out_RegWrite), 16'd1);
        chk("ld_memtoreg", 16'(out_MemToReg), 16'd1);
        chk("ld_stall_cycles", stall_cycles, 16'd3);
        chk("ld_req_drop", 16'(mem_req), 16'd0);
        // store with WB forwarding, two stalled cycles
        in_ALU_result = 16'h0080; in_MemWrite = 1'b1; in_RT = 4'd5; in_SW_data = 16'h0000;
        wb_RegWrite = 1'b1; wb_DstReg = 4'd5; wb_data = 16'hA5A5;
        #1;
        chk("st_fwd_wdata", mem_wdata, 16'hA5A5);
        chk("st_we", 16'(mem_we), 16'd1);
        chk("st_stall", 16'(mem_stall), 16'd1);
        tick();
        wb_DstReg = 4'd2; wb_data = 16'h1111;
        #1;
        chk("st_hold_wdata", mem_wdata, 16'hA5A5);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("st_hold_wdata2", mem_wdata, 16'hA5A5);
        tick();
        clear_in();
        #1;
        chk("st_stall_cycles", stall_cycles, 16'd5);
        // store from r0 with WB dst r0: no forward; read+write treated as write; zero wait
        in_MemWrite = 1'b1; in_MemRead = 1'b1; in_SW_data = 16'h1357;
        wb_RegWrite = 1'b1; wb_DstReg = 4'd0; wb_data = 16'h5555; mem_ready = 1'b1;
        #1;
        chk("st0_wdata", mem_wdata, 16'h1357);
        chk("st0_we", 16'(mem_we), 16'd1);
        chk("st0_stall", 16'(mem_stall), 16'd0);
        tick();
        clear_in();
        #1;
        chk("st0_stall_cycles", stall_cycles, 16'd5);
        // reset in the middle of a WAIT
        in_ALU_result = 16'h0100; in_MemRead = 1'b1; in_RegWrite = 1'b1;
        tick();
        chk("rw_stall", 16'(mem_stall), 16'd1);
        rst_n = 1'b0;
        tick();
        chk("rw_req", 16'(mem_req), 16'd0);
        chk("rw_alu", out_ALU_result, 16'd0);
        chk("rw_stall_cycles", stall_cycles, 16'd0);
        clear_in();
        rst_n = 1'b1;
        tick();
        chk("rw_idle_req", 16'(mem_req), 16'd0);
`ifdef MEM_TIMEOUT_EN
        in_ALU_result = 16'h0200; in_MemRead = 1'b1; in_RegWrite = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("to_err", 16'(mem_err), 16'd1);
        chk("to_stall", 16'(mem_stall), 16'd0);
        chk("to_req", 16'(mem_req), 16'd0);
        chk("to_stall_cycles", stall_cycles, 16'd5);
        tick();
        clear_in();
        #1;
        chk("to_regwrite", 16'(out_RegWrite), 16'd0);
        chk("to_err_sticky", 16'(mem_err), 16'd1);
`endif
        // halt marker sticks
        in_HLT = 1'b1;
        tick();
        chk("hlt_set", 16'(out_HLT), 16'd1);
        in_HLT = 1'b0;
        tick();
        chk("hlt_hold", 16'(out_HLT), 16'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
